hssl_reg_wr_arbiter: RTL and testbench
======================================

// Module: hssl_reg_wr_arbiter
// PURPOSE
//  Shares the single packet-side register write port (prx_addr/prx_wdata/prx_en) of the register bank
//  among NUM_REQ config-packet receivers (one per pipe/link). Arbitration is round-robin.
//  A lock supports atomic multi-word updates (e.g. router key+mask+route).
//  Writes reach the bank through one registered stage, one write per cycle max.
// PARAMETERS
//  NUM_REQ     4   number of requesters (>=2)
//  ADDR_BITS   16  register word address width (matches bank REG_ADR_BITS)
//  MAX_BURST   8   max words accepted per locked grant before forced release (>=1)
//  LOCK_TMO    64  max consecutive idle cycles in a locked grant before forced release (>=1)
// PORTS
//  clk            in   1                    clock
//  reset          in   1                    reset, asynchronous, active-high
//  req_vld_in     in   NUM_REQ              per-requester write request valid
//  req_lock_in    in   NUM_REQ              keep grant after this word (sampled on handshake)
//  req_addr_in    in   NUM_REQ*ADDR_BITS    packed addresses, requester i at [i*ADDR_BITS +: ADDR_BITS]
//  req_data_in    in   NUM_REQ*32           packed write data, requester i at [i*32 +: 32]
//  req_rdy_out    out  NUM_REQ              combinational ready, at most one bit set
//  prx_addr_out   out  ADDR_BITS            registered write address to bank
//  prx_wdata_out  out  32                   registered write data to bank
//  prx_en_out     out  1                    registered write strobe, one pulse per accepted word
//  grant_out      out  NUM_REQ              registered one-hot owner of the current lock, 0 when unlocked
//  lock_abort_out out  1                    one-cycle pulse on forced release (burst or timeout)
// BEHAVIOUR
//  Reset: prx_* = 0, grant_out = 0, lock_abort_out = 0.
//    Round-robin pointer last = NUM_REQ-1, so requester 0 has first priority. Counters = 0. State = OPEN.
//  Handshake: word i is accepted when req_vld_in[i] & req_rdy_out[i] are both high.
//    Requesters hold vld/addr/data stable until accepted. The bank never back-pressures.
//  OPEN state: req_rdy_out is one-hot on the first vld requester searching from last+1 with wrap-around.
//    All ready bits are 0 if no requester is valid.
//    Accepting word i sets last = i.
//    If req_lock_in[i] = 1, go to LOCKED(i) with burst_cnt = 1 and tmo_cnt = 0. Otherwise stay OPEN.
//  LOCKED(i) state: req_rdy_out = req_vld_in[i] on bit i only. All other requesters are stalled.
//    On handshake with lock = 0: return to OPEN.
//    On handshake with lock = 1: burst_cnt++ and tmo_cnt = 0. If burst_cnt reaches MAX_BURST, force OPEN and pulse lock_abort_out.
//    On a cycle with no handshake: tmo_cnt++. When tmo_cnt reaches LOCK_TMO, force OPEN and pulse lock_abort_out.
//    In that timeout cycle ready stays on i only.
//  Latency: word accepted in cycle N produces prx_en_out = 1 with its addr/data in cycle N+1. Back-to-back accepts give back-to-back strobes.
//  When no word is accepted, prx_en_out = 0 and prx_addr_out/prx_wdata_out hold their last value.
//  grant_out updates in cycle N+1 to reflect the state entered after cycle N.
//  Counter widths are $clog2(MAX_BURST+1) and $clog2(LOCK_TMO+1). Counters saturate and never wrap.
//  A MAX_BURST=1 lock is released by the abort path immediately after the first word.
//  Simultaneous vld from all requesters in OPEN: exactly one is granted per cycle, rotating fairly.
//    Each requester waits at most NUM_REQ-1 accepts (unlocked traffic).
//  Reset asserted mid-burst: lock is dropped and outputs clear immediately (async). No partial-word strobe is emitted.
//  Requester dropping vld without handshake is legal. In OPEN, arbitration re-evaluates every cycle.
// TESTING
//  1. Reset then idle: all outputs 0, req_rdy_out = 0.
//     Assert reset mid-burst: prx_en_out drops same cycle, grant_out = 0.
//  2. All 4 vld, lock = 0, distinct addrs: accepts go in order 0,1,2,3,0.
//     prx_en_out is continuous; each addr/data appears 1 cycle after its handshake.
//  3. Req 2 sends 3 words, lock = 1,1,0, while req 0,1 are vld: req 0,1 see rdy = 0 throughout.
//     grant_out = 0100 during the burst. The 3 writes are contiguous, then arbitration resumes at req 3 then 0.
//  4. MAX_BURST = 8: req 1 holds lock = 1 for 10 words.
//     The 8th accept triggers lock_abort_out; req 1 word 9 waits for its round-robin turn.
//  5. Req 0 locks, then drops vld for 64 cycles: lock_abort_out pulses on cycle 64 and grant_out clears.
//     Pending req 3 is accepted the next cycle.
//  6. Random vld/lock traffic: scoreboard checks every prx write matches a handshake, in order.
//     Checks include one-hot rdy, no starvation beyond NUM_REQ*MAX_BURST accepts, and no lost or duplicated word.

Source files
------------

// File: rtl/hssl_reg_wr_arbiter.sv
// rtl/hssl_reg_wr_arbiter.sv - round-robin arbiter with lock for the packet-side register write port
module hssl_reg_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_BITS = 16,
  parameter int MAX_BURST = 8,
  parameter int LOCK_TMO  = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_vld_in,
  input  logic [NUM_REQ-1:0]             req_lock_in,
  input  logic [NUM_REQ*ADDR_BITS-1:0]   req_addr_in,
  input  logic [NUM_REQ*32-1:0]          req_data_in,
  output logic [NUM_REQ-1:0]             req_rdy_out,
  output logic [ADDR_BITS-1:0]           prx_addr_out,
  output logic [31:0]                    prx_wdata_out,
  output logic                           prx_en_out,
  output logic [NUM_REQ-1:0]             grant_out,
  output logic                           lock_abort_out
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int TW = $clog2(LOCK_TMO + 1);

  localparam logic [0:0] ST_OPEN   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]           state, state_nx;
  logic [IW-1:0]        owner, owner_nx;
  logic [IW-1:0]        last, last_nx;
  logic [BW-1:0]        burst_cnt, burst_nx;
  logic [TW-1:0]        tmo_cnt, tmo_nx;
  logic                 abort_nx;
  logic [NUM_REQ-1:0]   grant_nx;

  logic [NUM_REQ-1:0]   rr_pick;
  logic [IW-1:0]        rr_idx;
  logic                 rr_found;
  logic [IW-1:0]        probe;

  logic                 hs;
  logic [IW-1:0]        sel;
  logic                 sel_lock;
  logic [ADDR_BITS-1:0] sel_addr;
  logic [31:0]          sel_data;

  // First valid requester after the last winner, wrapping around.
  always_comb begin
    rr_pick  = '0;
    rr_idx   = '0;
    rr_found = 1'b0;
    probe    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      probe = IW'((int'(last) + k) % NUM_REQ);
      if (!rr_found && req_vld_in[probe]) begin
        rr_found = 1'b1;
        rr_idx   = probe;
      end
    end
    if (rr_found) rr_pick[rr_idx] = 1'b1;
  end

  always_comb begin
    req_rdy_out = '0;
    if (state == ST_LOCKED) req_rdy_out[owner] = req_vld_in[owner];
    else                    req_rdy_out = rr_pick;
  end

  assign hs       = |(req_vld_in & req_rdy_out);
  assign sel      = (state == ST_LOCKED) ? owner : rr_idx;
  assign sel_lock = req_lock_in[sel];

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel == IW'(i)) begin
        sel_addr = req_addr_in[i*ADDR_BITS +: ADDR_BITS];
        sel_data = req_data_in[i*32 +: 32];
      end
    end
  end

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    last_nx  = last;
    burst_nx = burst_cnt;
    tmo_nx   = tmo_cnt;
    abort_nx = 1'b0;
    if (state == ST_OPEN) begin
      if (hs) begin
        last_nx = sel;
        if (sel_lock) begin
          // A single-word burst limit releases the lock on the very word that asked for it.
          if (MAX_BURST <= 1) begin
            abort_nx = 1'b1;
          end else begin
            state_nx = ST_LOCKED;
            owner_nx = sel;
            burst_nx = BW'(1);
            tmo_nx   = '0;
          end
        end
      end
    end else if (hs) begin
      tmo_nx = '0;
      if (!sel_lock) begin
        state_nx = ST_OPEN;
      end else begin
        if (int'(burst_cnt) < MAX_BURST) burst_nx = burst_cnt + BW'(1);
        if (int'(burst_cnt) + 1 >= MAX_BURST) begin
          state_nx = ST_OPEN;
          abort_nx = 1'b1;
        end
      end
    end else begin
      if (int'(tmo_cnt) < LOCK_TMO) tmo_nx = tmo_cnt + TW'(1);
      if (int'(tmo_cnt) + 1 >= LOCK_TMO) begin
        state_nx = ST_OPEN;
        abort_nx = 1'b1;
      end
    end
  end

  always_comb begin
    grant_nx = '0;
    if (state_nx == ST_LOCKED) grant_nx[owner_nx] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_OPEN;
      owner          <= '0;
      last           <= IW'(NUM_REQ - 1);
      burst_cnt      <= '0;
      tmo_cnt        <= '0;
      prx_addr_out   <= '0;
      prx_wdata_out  <= '0;
      prx_en_out     <= 1'b0;
      grant_out      <= '0;
      lock_abort_out <= 1'b0;
    end else begin
      state          <= state_nx;
      owner          <= owner_nx;
      last           <= last_nx;
      burst_cnt      <= burst_nx;
      tmo_cnt        <= tmo_nx;
      prx_en_out     <= hs;
      grant_out      <= grant_nx;
      lock_abort_out <= abort_nx;
      if (hs) begin
        prx_addr_out  <= sel_addr;
        prx_wdata_out <= sel_data;
      end
    end
  end

endmodule

// File: tb/tb_hssl_reg_wr_arbiter.sv
// tb/tb_hssl_reg_wr_arbiter.sv - directed table, lock corner cases and random scoreboard for hssl_reg_wr_arbiter
module tb_hssl_reg_wr_arbiter;
  localparam int N   = 4;
  localparam int AB  = 16;
  localparam int MB  = 8;
  localparam int TMO = 64;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_vld_in = '0;
  logic [N-1:0]    req_lock_in = '0;
  logic [N*AB-1:0] req_addr_in = '0;
  logic [N*32-1:0] req_data_in = '0;
  logic [N-1:0]    req_rdy_out;
  logic [AB-1:0]   prx_addr_out;
  logic [31:0]     prx_wdata_out;
  logic            prx_en_out;
  logic [N-1:0]    grant_out;
  logic            lock_abort_out;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [N-1:0] vld;
    logic [N-1:0] lock;
    logic [N-1:0] rdy;
    int           win;
    logic [N-1:0] grant;
    logic         abort;
  } vec_t;

  vec_t vq[$];

  logic [AB-1:0] exp_addr;
  logic [31:0]   exp_data;

  always #5 clk = ~clk;

  hssl_reg_wr_arbiter #(.NUM_REQ(N), .ADDR_BITS(AB), .MAX_BURST(MB), .LOCK_TMO(TMO)) dut (
    .clk(clk), .reset(reset),
    .req_vld_in(req_vld_in), .req_lock_in(req_lock_in),
    .req_addr_in(req_addr_in), .req_data_in(req_data_in),
    .req_rdy_out(req_rdy_out),
    .prx_addr_out(prx_addr_out), .prx_wdata_out(prx_wdata_out), .prx_en_out(prx_en_out),
    .grant_out(grant_out), .lock_abort_out(lock_abort_out)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [N-1:0] v, input logic [N-1:0] l, input logic [N-1:0] r,
                     input int w, input logic [N-1:0] g, input logic a);
    vec_t e;
    e.vld = v; e.lock = l; e.rdy = r; e.win = w; e.grant = g; e.abort = a;
    vq.push_back(e);
  endtask

  task automatic set_fixed();
    for (int i = 0; i < N; i++) begin
      req_addr_in[i*AB +: AB] = AB'(16'h0100 + i);
      req_data_in[i*32 +: 32] = 32'hD000_0000 + i;
    end
  endtask

  // Random-phase requester state
  logic [N-1:0]  pend;
  logic [AB-1:0] r_addr [N];
  logic [31:0]   r_data [N];
  logic [N-1:0]  r_lock;
  logic [AB+31:0] sb[$];
  int            waitc [N];
  int            maxw  [N];
  logic [N-1:0]  hsv;
  logic [AB+31:0] top;

  initial begin
    set_fixed();
    exp_addr = '0;
    exp_data = '0;

    // Reset state with everything idle
    #12;
    chk("rst_en", prx_en_out, 0);
    chk("rst_addr", prx_addr_out, 0);
    chk("rst_data", prx_wdata_out, 0);
    chk("rst_grant", grant_out, 0);
    chk("rst_abort", lock_abort_out, 0);
    chk("rst_rdy", req_rdy_out, 0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_en", prx_en_out, 0);

    // Fair rotation with all requesters valid
    add(4'hF, 4'h0, 4'h1, 0, 4'h0, 1'b0);
    add(4'hF, 4'h0, 4'h2, 1, 4'h0, 1'b0);
    add(4'hF, 4'h0, 4'h4, 2, 4'h0, 1'b0);
    add(4'hF, 4'h0, 4'h8, 3, 4'h0, 1'b0);
    add(4'hF, 4'h0, 4'h1, 0, 4'h0, 1'b0);
    // Req 2 locked 3-word burst while others wait, then rotation resumes at 3 then 0
    add(4'h2, 4'h0, 4'h2, 1, 4'h0, 1'b0);
    add(4'hF, 4'h4, 4'h4, 2, 4'h4, 1'b0);
    add(4'hF, 4'h4, 4'h4, 2, 4'h4, 1'b0);
    add(4'hF, 4'h0, 4'h4, 2, 4'h0, 1'b0);
    add(4'hB, 4'h0, 4'h8, 3, 4'h0, 1'b0);
    add(4'h3, 4'h0, 4'h1, 0, 4'h0, 1'b0);
    add(4'h0, 4'h0, 4'h0, -1, 4'h0, 1'b0);
    // Req 1 burst limit: 8th word aborts, word 9 waits behind req 3
    for (int k = 0; k < 7; k++) add(4'hA, 4'h2, 4'h2, 1, 4'h2, 1'b0);
    add(4'hA, 4'h2, 4'h2, 1, 4'h0, 1'b1);
    add(4'hA, 4'h2, 4'h8, 3, 4'h0, 1'b0);
    add(4'hA, 4'h2, 4'h2, 1, 4'h2, 1'b0);
    add(4'hA, 4'h2, 4'h2, 1, 4'h2, 1'b0);

    foreach (vq[k]) begin
      req_vld_in  = vq[k].vld;
      req_lock_in = vq[k].lock;
      @(negedge clk);
      chk($sformatf("v%0d_rdy", k), req_rdy_out, vq[k].rdy);
      @(posedge clk); #1;
      if (vq[k].win >= 0) begin
        exp_addr = AB'(16'h0100 + vq[k].win);
        exp_data = 32'hD000_0000 + vq[k].win;
      end
      chk($sformatf("v%0d_en", k), prx_en_out, (vq[k].win >= 0));
      chk($sformatf("v%0d_addr", k), prx_addr_out, exp_addr);
      chk($sformatf("v%0d_data", k), prx_wdata_out, exp_data);
      chk($sformatf("v%0d_grant", k), grant_out, vq[k].grant);
      chk($sformatf("v%0d_abort", k), lock_abort_out, vq[k].abort);
    end

    // Reset mid-burst while req 1 still holds the lock
    req_vld_in  = 4'h2;
    req_lock_in = 4'h2;
    @(posedge clk); #1;
    chk("mb_en_before", prx_en_out, 1);
    chk("mb_grant_before", grant_out, 4'h2);
    #2 reset = 1'b1;
    #1;
    chk("mb_en", prx_en_out, 0);
    chk("mb_grant", grant_out, 0);
    chk("mb_addr", prx_addr_out, 0);
    chk("mb_rdy_open", req_rdy_out, 4'h2);
    req_vld_in  = '0;
    req_lock_in = '0;
    @(negedge clk) reset = 1'b0;
    chk("mb_rdy_idle", req_rdy_out, 0);
    @(posedge clk); #1;
    chk("mb_no_strobe", prx_en_out, 0);

    // Lock timeout: req 0 locks then goes silent with req 3 pending
    req_vld_in  = 4'h1;
    req_lock_in = 4'h1;
    @(negedge clk);
    chk("to_rdy0", req_rdy_out, 4'h1);
    @(posedge clk); #1;
    chk("to_en0", prx_en_out, 1);
    chk("to_addr0", prx_addr_out, 16'h0100);
    chk("to_grant0", grant_out, 4'h1);
    req_vld_in  = 4'h8;
    req_lock_in = 4'h0;
    for (int k = 1; k <= TMO; k++) begin
      @(negedge clk);
      chk($sformatf("to%0d_rdy", k), req_rdy_out, 0);
      @(posedge clk); #1;
      chk($sformatf("to%0d_grant", k), grant_out, (k < TMO) ? 4'h1 : 4'h0);
      chk($sformatf("to%0d_abort", k), lock_abort_out, (k == TMO));
    end
    @(negedge clk);
    chk("to_rdy3", req_rdy_out, 4'h8);
    @(posedge clk); #1;
    chk("to_en3", prx_en_out, 1);
    chk("to_addr3", prx_addr_out, 16'h0103);
    chk("to_abort_end", lock_abort_out, 0);
    req_vld_in = '0;
    @(posedge clk); #1;

    // Random traffic with scoreboard
    pend   = '0;
    r_lock = '0;
    for (int i = 0; i < N; i++) begin
      waitc[i] = 0; maxw[i] = 0; r_addr[i] = '0; r_data[i] = '0;
    end
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 0)) begin
          pend[i]   = 1'b1;
          r_addr[i] = AB'($urandom);
          r_data[i] = $urandom;
          r_lock[i] = ($urandom_range(0, 1) == 0);
        end
        req_addr_in[i*AB +: AB] = r_addr[i];
        req_data_in[i*32 +: 32] = r_data[i];
      end
      req_vld_in  = pend;
      req_lock_in = r_lock;
      @(negedge clk);
      hsv = req_vld_in & req_rdy_out;
      chk("rnd_onehot", $onehot0(req_rdy_out), 1);
      chk("rnd_rdy_vld", req_rdy_out & ~req_vld_in, 0);
      for (int i = 0; i < N; i++) begin
        if (hsv[i]) begin
          sb.push_back({r_addr[i], r_data[i]});
          if (waitc[i] > maxw[i]) maxw[i] = waitc[i];
          waitc[i] = 0;
          pend[i]  = 1'b0;
        end else if (pend[i] && (hsv != 0)) begin
          waitc[i]++;
        end
      end
      @(posedge clk); #1;
      chk("rnd_en", prx_en_out, (hsv != 0));
      if (prx_en_out && sb.size() > 0) begin
        top = sb.pop_front();
        chk("rnd_wr", {prx_addr_out, prx_wdata_out}, top);
      end
    end
    req_vld_in = '0;
    @(posedge clk); #1;
    chk("rnd_tail_en", prx_en_out, 0);
    chk("rnd_sb_empty", sb.size(), 0);
    for (int i = 0; i < N; i++) begin
      if (waitc[i] > maxw[i]) maxw[i] = waitc[i];
      chk($sformatf("rnd_starve%0d", i), (maxw[i] <= N*MB), 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
